// File: rtl/ex_hazard_sequencer_if.sv
// Control bundle between the ID/EX pipeline registers and the EX hazard sequencer.
// The pipeline side drives hazard inputs (master); the sequencer returns stall/flush controls (slave).
interface ex_hazard_sequencer_if #(
   parameter int IDX_W  = 3,
   parameter int PERF_W = 16
);
   logic [4:0]        ifid_rs1;
   logic [4:0]        ifid_rs2;
   logic              ifid_uses_rs2;
   logic [4:0]        idex_rd;
   logic              idex_memtoreg;
   logic              idex_WVRwrite;
   logic              idex_SVRwrite;
   logic [1:0]        idex_VL;
   logic              branch_taken;
   logic              pc_write;
   logic              ifid_write;
   logic              ifid_flush;
   logic              idex_hold;
   logic              idex_flush;
   logic [IDX_W-1:0]  elem_idx;
   logic              elem_last;
   logic              vec_busy;
   logic [PERF_W-1:0] stall_cycles;

   modport master (
      output ifid_rs1, ifid_rs2, ifid_uses_rs2, idex_rd, idex_memtoreg,
             idex_WVRwrite, idex_SVRwrite, idex_VL, branch_taken,
      input  pc_write, ifid_write, ifid_flush, idex_hold, idex_flush,
             elem_idx, elem_last, vec_busy, stall_cycles
   );

   modport slave (
      input  ifid_rs1, ifid_rs2, ifid_uses_rs2, idex_rd, idex_memtoreg,
             idex_WVRwrite, idex_SVRwrite, idex_VL, branch_taken,
      output pc_write, ifid_write, ifid_flush, idex_hold, idex_flush,
             elem_idx, elem_last, vec_busy, stall_cycles
   );
endinterface

// File: rtl/ex_hazard_sequencer.sv
// ID/EX hazard control: load-use bubbles, branch flushes, and multi-element vector
// sequencing that holds ID/EX while stepping an element index; counts stall cycles.
module ex_hazard_sequencer #(
   parameter int IDX_W  = 3,
   parameter int PERF_W = 16
) (
   input logic                   clk,
   input logic                   reset,
   ex_hazard_sequencer_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      VEC  = 1'b1
   } state_t;

   state_t            state, state_nx;
   logic [IDX_W-1:0]  cnt, cnt_nx;
   logic [PERF_W-1:0] stall_q;
   logic [IDX_W:0]    n_elems;
   logic [IDX_W-1:0]  last_idx;
   logic              vec;
   logic              lu;

   logic              pc_write_c, ifid_write_c, ifid_flush_c;
   logic              idex_hold_c, idex_flush_c, elem_last_c, vec_busy_c;
   logic [IDX_W-1:0]  elem_idx_c;

   assign vec      = bus.idex_WVRwrite | bus.idex_SVRwrite;
   assign n_elems  = (IDX_W+1)'(1) << bus.idex_VL;
   assign last_idx = IDX_W'(n_elems - (IDX_W+1)'(1));
   assign lu       = bus.idex_memtoreg && (bus.idex_rd != 5'd0) &&
                     ((bus.idex_rd == bus.ifid_rs1) ||
                      (bus.ifid_uses_rs2 && (bus.idex_rd == bus.ifid_rs2)));

   // NOTE: sequential state uses non-blocking assignments and an async reset
   // so every register samples the pre-edge values of the combinational logic.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= '0;
      end else if (!pc_write_c && (stall_q != {PERF_W{1'b1}})) begin
         stall_q <= stall_q + PERF_W'(1);
      end
   end

   // NOTE: every output and next-state value gets a default before any branch,
   // so no path through this block can leave a signal unassigned (no latches).
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      pc_write_c   = 1'b1;
      ifid_write_c = 1'b1;
      ifid_flush_c = 1'b0;
      idex_hold_c  = 1'b0;
      idex_flush_c = 1'b0;
      elem_idx_c   = cnt;
      elem_last_c  = 1'b0;
      vec_busy_c   = (state == VEC);

      if (reset) begin
         elem_idx_c = '0;
         vec_busy_c = 1'b0;
      end else if (bus.branch_taken) begin
         ifid_flush_c = 1'b1;
         idex_flush_c = 1'b1;
         state_nx     = IDLE;
         cnt_nx       = '0;
      end else if (state == VEC) begin
         // A VL change mid-sequence cannot strand us: anything at or past the end is last.
         if (cnt >= last_idx) begin
            elem_last_c = 1'b1;
            state_nx    = IDLE;
            cnt_nx      = '0;
         end else begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            idex_hold_c  = 1'b1;
            cnt_nx       = cnt + IDX_W'(1);
         end
      end else if (vec && (bus.idex_VL != 2'b00)) begin
         elem_idx_c   = '0;
         pc_write_c   = 1'b0;
         ifid_write_c = 1'b0;
         idex_hold_c  = 1'b1;
         state_nx     = VEC;
         cnt_nx       = IDX_W'(1);
      end else begin
         if (vec) begin
            elem_idx_c  = '0;
            elem_last_c = 1'b1;
         end
         if (lu) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            idex_flush_c = 1'b1;
         end
      end
   end

   assign bus.pc_write     = pc_write_c;
   assign bus.ifid_write   = ifid_write_c;
   assign bus.ifid_flush   = ifid_flush_c;
   assign bus.idex_hold    = idex_hold_c;
   assign bus.idex_flush   = idex_flush_c;
   assign bus.elem_idx     = elem_idx_c;
   assign bus.elem_last    = elem_last_c;
   assign bus.vec_busy     = vec_busy_c;
   assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_ex_hazard_sequencer.sv
// Bench for ex_hazard_sequencer: a behavioural model tracks vector progress and stall
// totals and is compared every cycle, alongside directed literal expectations.
module tb_ex_hazard_sequencer;

   localparam int IDX_W  = 3;
   localparam int PERF_W = 16;
   localparam int SAT    = (1 << PERF_W) - 1;

   logic clk;
   logic reset;

   ex_hazard_sequencer_if #(.IDX_W(IDX_W), .PERF_W(PERF_W)) bus ();

   ex_hazard_sequencer #(.IDX_W(IDX_W), .PERF_W(PERF_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit pc_write, ifid_write, ifid_flush, idex_hold, idex_flush, elem_last, vec_busy;
      int elem_idx;
   } exp_t;

   bit m_in_vec;   // a multi-element op is mid-sequence in EX
   int m_idx;      // element currently being executed
   int m_stalls;

   function automatic exp_t expect_now();
      exp_t e;
      int   n;
      bit   vec_op;
      bit   lu;
      n      = 1 << int'(bus.idex_VL);
      vec_op = bus.idex_WVRwrite || bus.idex_SVRwrite;
      lu     = bus.idex_memtoreg && (bus.idex_rd != 0) &&
               ((bus.idex_rd == bus.ifid_rs1) || (bus.ifid_uses_rs2 && bus.idex_rd == bus.ifid_rs2));
      e.pc_write = 1; e.ifid_write = 1; e.ifid_flush = 0; e.idex_hold = 0;
      e.idex_flush = 0; e.elem_last = 0; e.vec_busy = m_in_vec; e.elem_idx = m_idx;
      if (reset) begin
         e.vec_busy = 0; e.elem_idx = 0;
      end else if (bus.branch_taken) begin
         e.ifid_flush = 1; e.idex_flush = 1;
      end else if (m_in_vec) begin
         if (m_idx >= n - 1) e.elem_last = 1;
         else begin e.pc_write = 0; e.ifid_write = 0; e.idex_hold = 1; end
      end else if (vec_op && n > 1) begin
         e.elem_idx = 0; e.pc_write = 0; e.ifid_write = 0; e.idex_hold = 1;
      end else begin
         if (vec_op) begin e.elem_idx = 0; e.elem_last = 1; end
         if (lu) begin e.pc_write = 0; e.ifid_write = 0; e.idex_flush = 1; end
      end
      return e;
   endfunction

   always @(posedge clk or posedge reset) begin
      exp_t e;
      int   n;
      if (reset) begin
         m_in_vec <= 0; m_idx <= 0; m_stalls <= 0;
      end else begin
         e = expect_now();
         n = 1 << int'(bus.idex_VL);
         if (!e.pc_write && m_stalls < SAT) m_stalls <= m_stalls + 1;
         if (bus.branch_taken) begin
            m_in_vec <= 0; m_idx <= 0;
         end else if (m_in_vec) begin
            if (m_idx >= n - 1) begin m_in_vec <= 0; m_idx <= 0; end
            else m_idx <= m_idx + 1;
         end else if ((bus.idex_WVRwrite || bus.idex_SVRwrite) && n > 1) begin
            m_in_vec <= 1; m_idx <= 1;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      e = expect_now();
      check("pc_write",     32'(bus.pc_write),     32'(e.pc_write));
      check("ifid_write",   32'(bus.ifid_write),   32'(e.ifid_write));
      check("ifid_flush",   32'(bus.ifid_flush),   32'(e.ifid_flush));
      check("idex_hold",    32'(bus.idex_hold),    32'(e.idex_hold));
      check("idex_flush",   32'(bus.idex_flush),   32'(e.idex_flush));
      check("elem_idx",     32'(bus.elem_idx),     32'(e.elem_idx));
      check("elem_last",    32'(bus.elem_last),    32'(e.elem_last));
      check("vec_busy",     32'(bus.vec_busy),     32'(e.vec_busy));
      check("stall_cycles", 32'(bus.stall_cycles), 32'(m_stalls));
      check("hold_and_flush_exclusive", 32'(bus.idex_hold & bus.idex_flush), 32'd0);
      check("ifid_flush_implies_idex", 32'(bus.ifid_flush & ~bus.idex_flush), 32'd0);
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses2,
                         input logic [4:0] rd, input logic mem);
      bus.ifid_rs1 = rs1; bus.ifid_rs2 = rs2; bus.ifid_uses_rs2 = uses2;
      bus.idex_rd = rd; bus.idex_memtoreg = mem;
   endtask

   initial begin
      reset = 1'b1;
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
      bus.idex_WVRwrite = 1'b0; bus.idex_SVRwrite = 1'b0;
      bus.idex_VL = 2'b00; bus.branch_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc_write", 32'(bus.pc_write), 32'd1);
      check("rst_elem_idx", 32'(bus.elem_idx), 32'd0);
      check("rst_stalls",   32'(bus.stall_cycles), 32'd0);

      // No hazard: load into x5, ID reads x3
      reset = 1'b0;
      set_in(5'd3, 5'd0, 1'b0, 5'd5, 1'b1);
      repeat (3) begin
         @(negedge clk);
         check("nohaz_pc_write", 32'(bus.pc_write), 32'd1);
         check("nohaz_flush",    32'(bus.idex_flush), 32'd0);
         check("nohaz_stalls",   32'(bus.stall_cycles), 32'd0);
         tick();
      end

      // Load-use through rs2
      set_in(5'd0, 5'd7, 1'b1, 5'd7, 1'b1);
      @(negedge clk);
      check("lu2_pc_write", 32'(bus.pc_write), 32'd0);
      check("lu2_flush",    32'(bus.idex_flush), 32'd1);
      tick();
      bus.idex_memtoreg = 1'b0;
      @(negedge clk);
      check("lu2_stalls", 32'(bus.stall_cycles), 32'd1);
      tick();

      // rd=x0 never hazards
      set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      @(negedge clk);
      check("x0_pc_write", 32'(bus.pc_write), 32'd1);
      tick();

      // rs2 match ignored when rs2 is not read
      set_in(5'd1, 5'd7, 1'b0, 5'd7, 1'b1);
      @(negedge clk);
      check("nors2_pc_write", 32'(bus.pc_write), 32'd1);
      tick();

      // Load-use through rs1
      set_in(5'd9, 5'd0, 1'b0, 5'd9, 1'b1);
      @(negedge clk);
      check("lu1_flush", 32'(bus.idex_flush), 32'd1);
      tick();
      bus.idex_memtoreg = 1'b0;
      @(negedge clk);
      check("lu1_stalls", 32'(bus.stall_cycles), 32'd2);
      tick();

      // 4-element vector
      bus.idex_WVRwrite = 1'b1; bus.idex_VL = 2'b10;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("v4_idx",  32'(bus.elem_idx),  32'(i));
         check("v4_hold", 32'(bus.idex_hold), (i < 3) ? 32'd1 : 32'd0);
         check("v4_last", 32'(bus.elem_last), (i == 3) ? 32'd1 : 32'd0);
         check("v4_busy", 32'(bus.vec_busy),  (i > 0) ? 32'd1 : 32'd0);
         tick();
      end
      bus.idex_WVRwrite = 1'b0;
      @(negedge clk);
      check("v4_stalls", 32'(bus.stall_cycles), 32'd5);
      check("v4_done_busy", 32'(bus.vec_busy), 32'd0);
      tick();

      // Single-element vector
      bus.idex_SVRwrite = 1'b1; bus.idex_VL = 2'b00;
      @(negedge clk);
      check("v1_last", 32'(bus.elem_last), 32'd1);
      check("v1_hold", 32'(bus.idex_hold), 32'd0);
      check("v1_busy", 32'(bus.vec_busy),  32'd0);
      tick();
      bus.idex_SVRwrite = 1'b0;
      @(negedge clk);
      check("v1_stalls", 32'(bus.stall_cycles), 32'd5);
      tick();

      // Branch aborts an 8-element vector at element 1
      bus.idex_WVRwrite = 1'b1; bus.idex_VL = 2'b11;
      @(negedge clk);
      check("br_idx0", 32'(bus.elem_idx), 32'd0);
      tick();
      bus.branch_taken = 1'b1;
      @(negedge clk);
      check("br_idx1",       32'(bus.elem_idx),   32'd1);
      check("br_ifid_flush", 32'(bus.ifid_flush), 32'd1);
      check("br_idex_flush", 32'(bus.idex_flush), 32'd1);
      check("br_hold",       32'(bus.idex_hold),  32'd0);
      tick();
      bus.branch_taken = 1'b0; bus.idex_WVRwrite = 1'b0;
      @(negedge clk);
      check("br_after_busy", 32'(bus.vec_busy), 32'd0);
      check("br_after_idx",  32'(bus.elem_idx), 32'd0);
      check("br_stalls",     32'(bus.stall_cycles), 32'd6);
      tick();

      // Multi-element vector coinciding with load-use: hold wins
      bus.idex_WVRwrite = 1'b1; bus.idex_VL = 2'b01;
      set_in(5'd7, 5'd0, 1'b0, 5'd7, 1'b1);
      @(negedge clk);
      check("vlu_hold",  32'(bus.idex_hold),  32'd1);
      check("vlu_flush", 32'(bus.idex_flush), 32'd0);
      tick();
      @(negedge clk);
      check("vlu_last",  32'(bus.elem_last),  32'd1);
      check("vlu_pc",    32'(bus.pc_write),   32'd1);
      tick();
      bus.idex_WVRwrite = 1'b0; bus.idex_memtoreg = 1'b0;
      @(negedge clk);
      check("vlu_stalls", 32'(bus.stall_cycles), 32'd7);
      tick();

      // Reset mid-vector at element 2
      bus.idex_WVRwrite = 1'b1; bus.idex_VL = 2'b11;
      repeat (2) begin
         @(negedge clk);
         tick();
      end
      @(negedge clk);
      check("rv_idx2", 32'(bus.elem_idx), 32'd2);
      reset = 1'b1;
      #1;
      check("rv_pc_write", 32'(bus.pc_write),     32'd1);
      check("rv_hold",     32'(bus.idex_hold),    32'd0);
      check("rv_idx",      32'(bus.elem_idx),     32'd0);
      check("rv_last",     32'(bus.elem_last),    32'd0);
      check("rv_busy",     32'(bus.vec_busy),     32'd0);
      check("rv_stalls",   32'(bus.stall_cycles), 32'd0);
      tick();
      reset = 1'b0; bus.idex_WVRwrite = 1'b0;
      @(negedge clk);
      check("rv_after_busy", 32'(bus.vec_busy), 32'd0);
      check("rv_after_idx",  32'(bus.elem_idx), 32'd0);
      tick();
      repeat (2) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_hazard_sequencer.md
Name: ex_hazard_sequencer

Overview:
- Pipeline control for the ID/EX boundary of the RV32 + vector-extension core.
- Detects load-use hazards and inserts bubbles into ID/EX.
- Applies branch-taken flushes to IF/ID and ID/EX.
- Sequences multi-element vector instructions (WVR/SVR writes) in EX by holding ID/EX and the front end while it steps an element index.
- Keeps a saturating count of stall cycles for performance debug.

Parameters:
- IDX_W, 3, width of the element index; the maximum element count is 2^IDX_W = 8.
- PERF_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ifid_rs1  input  5  rs1 of the instruction in ID.
- ifid_rs2  input  5  rs2 of the instruction in ID.
- ifid_uses_rs2  input  1  the ID instruction reads rs2 (R/S/B-type).
- idex_rd  input  5  rd of the instruction in EX.
- idex_memtoreg  input  1  the EX instruction is a load.
- idex_WVRwrite  input  1  the EX instruction writes the wide vector register.
- idex_SVRwrite  input  1  the EX instruction writes the scalar-vector register.
- idex_VL  input  2  vector length code; element count N = 1 << VL (1, 2, 4, 8).
- branch_taken  input  1  branch resolved taken (from EX/MEM).
- pc_write  output  1  PC update enable.
- ifid_write  output  1  IF/ID load enable.
- ifid_flush  output  1  clears IF/ID.
- idex_hold  output  1  ID/EX keeps its current contents.
- idex_flush  output  1  drives the ID/EX flush input (loads a bubble).
- elem_idx  output  IDX_W  element index for the vector datapath in EX.
- elem_last  output  1  the current EX cycle is the final element of a vector op.
- vec_busy  output  1  the FSM is in VEC.
- stall_cycles  output  PERF_W  saturating count of cycles with pc_write=0.

Behaviour:
- Reset is asynchronous and active-high, per the fixed interface decision.
- Reset values:
  - state=IDLE, cnt=0, stall_cycles=0.
  - While reset is high, outputs are forced to: pc_write=1, ifid_write=1, ifid_flush=0, idex_hold=0, idex_flush=0, elem_idx=0, elem_last=0, vec_busy=0.
- Definitions:
  - vec = idex_WVRwrite | idex_SVRwrite.
  - N = 1 << idex_VL.
  - lu (load-use) = idex_memtoreg & (idex_rd != 0) & ((idex_rd == ifid_rs1) | (ifid_uses_rs2 & idex_rd == ifid_rs2)).
- Default outputs are pc_write=1, ifid_write=1, all flush/hold=0, elem_idx=cnt.
- FSM has two states: IDLE and VEC. Outputs are combinational from state, cnt and inputs.
- Priority 1, branch_taken=1 (any state):
  - ifid_flush=1, idex_flush=1, pc_write=1, idex_hold=0, elem_last=0.
  - Next state=IDLE, cnt=0. This aborts any vector sequence in progress.
- Priority 2, IDLE with vec and VL=00:
  - Single element: elem_idx=0, elem_last=1, no stall.
  - The load-use check still applies.
- Priority 3, IDLE with vec and VL!=00:
  - elem_idx=0, elem_last=0.
  - pc_write=0, ifid_write=0, idex_hold=1.
  - Next state=VEC, cnt=1.
- Priority 4, VEC:
  - elem_idx=cnt.
  - While cnt < N-1: pc_write=0, ifid_write=0, idex_hold=1, cnt++.
  - When cnt == N-1: elem_last=1, hold and stall are released, next state=IDLE, cnt=0.
  - Load-use is not evaluated in VEC.
  - An N-element op therefore occupies EX for exactly N cycles and stalls the front end for N-1 cycles.
- Priority 5, IDLE with lu=1 (not otherwise held):
  - pc_write=0, ifid_write=0, idex_flush=1, giving one bubble.
  - When a multi-element vec and lu coincide in IDLE, the vector hold wins; lu is re-evaluated once EX advances.
- Constraints:
  - idex_hold and idex_flush are never both 1.
  - ifid_flush implies idex_flush.
- idex_VL is sampled every cycle in VEC. It is stable there because ID/EX is held; if it were not, cnt >= N-1 is treated as last.
- stall_cycles increments every cycle with pc_write=0 and saturates at 2^PERF_W-1.
- Reset asserted mid-VEC returns the FSM to IDLE immediately and forces the reset output values; no partial element is reported.

Test Plan:
- Reset release, no hazards, rs1=3, idex_rd=5, memtoreg=1 -> pc_write=1, idex_flush=0, stall_cycles stays 0.
- Load-use: idex_memtoreg=1, idex_rd=7, ifid_rs2=7, uses_rs2=1 -> one cycle with pc_write=0, idex_flush=1, stall_cycles=1.
  - Same stimulus with idex_rd=0 -> no stall.
- Vector, idex_WVRwrite=1, VL=10 (N=4):
  - elem_idx=0,1,2,3 over 4 cycles.
  - idex_hold=1 for the first 3 cycles; elem_last=1 only on idx 3.
  - vec_busy high for cycles 2-4; stall_cycles=3.
- Vector VL=00 -> elem_idx=0, elem_last=1, no hold, vec_busy=0.
- branch_taken=1 while in VEC at elem_idx=1 (VL=11) -> same cycle ifid_flush=idex_flush=1, idex_hold=0; next cycle state IDLE, elem_idx=0.
- Assert reset in VEC at elem_idx=2 -> outputs go to reset values immediately, stall_cycles=0; after release, state IDLE.
